// File: rtl/product_accumulator.sv
// Accumulates unsigned multiplier products into groups closed by a last flag or a term limit.
// The finished group is held on a valid/ready output until it is taken.
module product_accumulator #(
  parameter int unsigned PROD_W    = 18,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned MAX_TERMS = 256,
  localparam int unsigned CNT_W    = $clog2(MAX_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic StAccum = 1'b0;
  localparam logic StHold  = 1'b1;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_TERMS);

  logic             state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovfo_q, ovfo_d;
  logic             valid_q, valid_d;

  logic             accept;
  logic             take;
  logic             close;
  logic [ACC_W:0]   sum_ext;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_nxt;

  assign in_ready     = (state_q == StAccum) && !rst && !clear;
  assign accept       = in_valid && in_ready;
  assign take         = valid_q && out_ready;
  // One extra bit keeps the carry out of the accumulator for the overflow flag.
  assign sum_ext      = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
  assign cnt_inc      = cnt_q + CntOne;
  assign ovf_nxt      = ovf_q | sum_ext[ACC_W];
  assign close        = in_last || (cnt_inc == CntMax);

  assign out_sum      = sum_q;
  assign out_count    = count_q;
  assign out_overflow = ovfo_q;
  assign out_valid    = valid_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    count_d = count_q;
    ovfo_d  = ovfo_q;
    valid_d = valid_q;
    unique case (state_q)
      StAccum: begin
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (accept) begin
          if (close) begin
            sum_d   = sum_ext[ACC_W-1:0];
            count_d = cnt_inc;
            ovfo_d  = ovf_nxt;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = StHold;
          end else begin
            acc_d = sum_ext[ACC_W-1:0];
            cnt_d = cnt_inc;
            ovf_d = ovf_nxt;
          end
        end
      end
      StHold: begin
        if (take) begin
          valid_d = 1'b0;
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      ovfo_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      ovfo_q  <= ovfo_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Table-driven bench for product_accumulator across three parameterisations.
module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a   [3];
  logic        clear_a [3];
  logic        valid_a [3];
  logic        last_a  [3];
  logic        ordy_a  [3];
  logic [17:0] prod_a  [3];

  logic        ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2;
  logic [31:0] sum0, sum2;
  logic [19:0] sum1;
  logic [8:0]  cnt0, cnt1;
  logic [1:0]  cnt2;

  // Instance 0: defaults; 1: 20-bit accumulator; 2: three-term groups.
  product_accumulator #(.PROD_W(18), .ACC_W(32), .MAX_TERMS(256)) u_dut0 (
    .clk(clk), .rst(rst_a[0]), .clear(clear_a[0]), .in_product(prod_a[0]),
    .in_valid(valid_a[0]), .in_last(last_a[0]), .in_ready(ir0), .out_sum(sum0),
    .out_count(cnt0), .out_overflow(of0), .out_valid(ov0), .out_ready(ordy_a[0])
  );
  product_accumulator #(.PROD_W(18), .ACC_W(20), .MAX_TERMS(256)) u_dut1 (
    .clk(clk), .rst(rst_a[1]), .clear(clear_a[1]), .in_product(prod_a[1]),
    .in_valid(valid_a[1]), .in_last(last_a[1]), .in_ready(ir1), .out_sum(sum1),
    .out_count(cnt1), .out_overflow(of1), .out_valid(ov1), .out_ready(ordy_a[1])
  );
  product_accumulator #(.PROD_W(18), .ACC_W(32), .MAX_TERMS(3)) u_dut2 (
    .clk(clk), .rst(rst_a[2]), .clear(clear_a[2]), .in_product(prod_a[2]),
    .in_valid(valid_a[2]), .in_last(last_a[2]), .in_ready(ir2), .out_sum(sum2),
    .out_count(cnt2), .out_overflow(of2), .out_valid(ov2), .out_ready(ordy_a[2])
  );

  // chk: 0 = in_ready only, 1 = also out_valid, 2 = also sum/count/overflow.
  typedef struct {
    int inst;
    int rst, clr, v, last, p, ordy;
    int eir, chk, eov, esum, ecnt, eovf;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic av(input int inst, input int rst, input int clr, input int v, input int last,
                    input int p, input int ordy, input int eir, input int chk, input int eov,
                    input int esum, input int ecnt, input int eovf);
    vec_t t;
    t.inst = inst; t.rst = rst; t.clr = clr; t.v = v; t.last = last; t.p = p; t.ordy = ordy;
    t.eir = eir; t.chk = chk; t.eov = eov; t.esum = esum; t.ecnt = ecnt; t.eovf = eovf;
    vq.push_back(t);
  endtask

  task automatic cmp(input int idx, input string name, input int act, input int exp);
    if (act != exp) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %0d expected %0d", idx, name, act, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_a[k] = 1'b1; clear_a[k] = 1'b0; valid_a[k] = 1'b0;
      last_a[k] = 1'b0; ordy_a[k] = 1'b0; prod_a[k] = '0;
    end

    //  inst rst clr v last prod ordy | ir chk ov sum cnt ovf
    // Instance 0: basic group, backpressure, clear, reset mid-group and in hold.
    av(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    av(0, 1, 0, 0, 0, 0,   0, 0, 2, 0, 0, 0, 0);
    av(0, 0, 0, 1, 0, 4,   1, 1, 1, 0, 0, 0, 0);
    av(0, 0, 0, 1, 1, 16,  1, 1, 1, 0, 0, 0, 0);
    av(0, 0, 0, 0, 0, 0,   1, 0, 2, 1, 20, 2, 0);
    av(0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
    av(0, 0, 0, 1, 0, 1,   1, 1, 1, 0, 0, 0, 0);
    av(0, 0, 0, 1, 0, 2,   1, 1, 1, 0, 0, 0, 0);
    av(0, 0, 0, 1, 1, 3,   1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) av(0, 0, 0, 1, 1, 50, 0, 0, 2, 1, 6, 3, 0);
    av(0, 0, 0, 1, 1, 50,  1, 0, 2, 1, 6, 3, 0);
    av(0, 0, 0, 1, 1, 50,  1, 1, 1, 0, 0, 0, 0);
    av(0, 0, 0, 0, 0, 0,   1, 0, 2, 1, 50, 1, 0);
    av(0, 0, 0, 1, 0, 5,   1, 1, 1, 0, 0, 0, 0);
    av(0, 0, 0, 1, 0, 6,   1, 1, 1, 0, 0, 0, 0);
    av(0, 0, 1, 1, 0, 9,   1, 0, 1, 0, 0, 0, 0);
    av(0, 0, 0, 1, 1, 8,   1, 1, 1, 0, 0, 0, 0);
    av(0, 0, 0, 0, 0, 0,   1, 0, 2, 1, 8, 1, 0);
    av(0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);
    av(0, 0, 0, 1, 0, 100, 1, 1, 1, 0, 0, 0, 0);
    av(0, 0, 0, 1, 0, 200, 1, 1, 1, 0, 0, 0, 0);
    av(0, 1, 0, 1, 0, 7,   1, 0, 1, 0, 0, 0, 0);
    av(0, 0, 0, 1, 1, 3,   1, 1, 2, 0, 0, 0, 0);
    av(0, 0, 0, 0, 0, 0,   0, 0, 2, 1, 3, 1, 0);
    av(0, 1, 0, 0, 0, 0,   0, 0, 2, 1, 3, 1, 0);
    av(0, 0, 0, 0, 0, 0,   0, 1, 2, 0, 0, 0, 0);

    // Instance 1: wrap and sticky overflow with a 20-bit accumulator.
    av(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    av(1, 1, 0, 0, 0, 0,   0, 0, 2, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) av(1, 0, 0, 1, (i == 4), 'h3FFFF, 1, 1, 1, 0, 0, 0, 0);
    av(1, 0, 0, 0, 0, 0,   1, 0, 2, 1, 262139, 5, 1);
    av(1, 0, 0, 1, 1, 7,   1, 1, 1, 0, 0, 0, 0);
    av(1, 0, 0, 0, 0, 0,   1, 0, 2, 1, 7, 1, 0);
    for (int i = 0; i < 5; i++) av(1, 0, 0, 1, 0, 'h3FFFF, 1, 1, 1, 0, 0, 0, 0);
    av(1, 0, 0, 1, 1, 1,   1, 1, 1, 0, 0, 0, 0);
    av(1, 0, 0, 0, 0, 0,   1, 0, 2, 1, 262140, 6, 1);
    av(1, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);

    // Instance 2: forced close at three terms.
    av(2, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    av(2, 1, 0, 0, 0, 0,   0, 0, 2, 0, 0, 0, 0);
    av(2, 0, 0, 1, 0, 10,  1, 1, 1, 0, 0, 0, 0);
    av(2, 0, 0, 1, 0, 20,  1, 1, 1, 0, 0, 0, 0);
    av(2, 0, 0, 1, 0, 30,  1, 1, 1, 0, 0, 0, 0);
    av(2, 0, 0, 1, 0, 40,  1, 0, 2, 1, 60, 3, 0);
    av(2, 0, 0, 1, 0, 40,  1, 1, 1, 0, 0, 0, 0);
    av(2, 0, 0, 1, 1, 1,   1, 1, 1, 0, 0, 0, 0);
    av(2, 0, 0, 0, 0, 0,   1, 0, 2, 1, 41, 2, 0);
    av(2, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0);

    foreach (vq[i]) begin
      int k;
      int a_ir, a_ov, a_sum, a_cnt, a_of;
      k = vq[i].inst;
      @(negedge clk);
      rst_a[k]   = (vq[i].rst != 0);
      clear_a[k] = (vq[i].clr != 0);
      valid_a[k] = (vq[i].v != 0);
      last_a[k]  = (vq[i].last != 0);
      ordy_a[k]  = (vq[i].ordy != 0);
      prod_a[k]  = 18'(vq[i].p);
      #1;
      case (k)
        0: begin
          a_ir = int'(ir0); a_ov = int'(ov0); a_sum = int'(sum0);
          a_cnt = int'(cnt0); a_of = int'(of0);
        end
        1: begin
          a_ir = int'(ir1); a_ov = int'(ov1); a_sum = int'({12'b0, sum1});
          a_cnt = int'(cnt1); a_of = int'(of1);
        end
        default: begin
          a_ir = int'(ir2); a_ov = int'(ov2); a_sum = int'(sum2);
          a_cnt = int'(cnt2); a_of = int'(of2);
        end
      endcase
      n_vec++;
      cmp(i, "in_ready", a_ir, vq[i].eir);
      if (vq[i].chk >= 1) cmp(i, "out_valid", a_ov, vq[i].eov);
      if (vq[i].chk >= 2) begin
        cmp(i, "out_sum", a_sum, vq[i].esum);
        cmp(i, "out_count", a_cnt, vq[i].ecnt);
        cmp(i, "out_overflow", a_of, vq[i].eovf);
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of the 9x9 unsigned multiplier.
- Consumes its 18-bit products through a valid/ready stream and sums them into groups (dot-product style).
- Each group closes on an explicit last flag or at a maximum term count.
- Emits the group sum, term count and an overflow flag on a held output handshake.

Parameters:
- PROD_W, 18, product input width; matches the multiplier output.
- ACC_W, 32, accumulator and output sum width; must be >= PROD_W.
- MAX_TERMS, 256, forced group length; must be >= 1.
- CNT_W, $clog2(MAX_TERMS+1), term counter width; derived, not overridden.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  discards the partial group being accumulated.
- in_product  input  PROD_W  unsigned product from the multiplier.
- in_valid  input  1  in_product is valid.
- in_last  input  1  beat closes the current group.
- in_ready  output  1  block accepts a beat this cycle.
- out_sum  output  ACC_W  group sum, modulo 2^ACC_W.
- out_count  output  CNT_W  number of terms in the group.
- out_overflow  output  1  carry out of ACC_W occurred during the group.
- out_valid  output  1  out_* fields are valid.
- out_ready  input  1  consumer takes the result.

Behaviour:
- Clock/reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - state=ACCUM; acc=0, cnt=0, ovf=0.
  - out_sum=0, out_count=0, out_overflow=0, out_valid=0.
  - in_ready=0 while rst is high.
- Handshakes:
  - Beat accepted iff in_valid && in_ready at the clock edge.
  - Result taken iff out_valid && out_ready.
- in_ready = (state==ACCUM) && !rst && !clear.
- State ACCUM, on an accepted beat:
  - s = acc + zero-extended in_product, computed ACC_W+1 bits wide.
  - c = cnt + 1; o = ovf | s[ACC_W].
  - Close condition: in_last==1 or c==MAX_TERMS.
  - Not closing: acc<=s[ACC_W-1:0], cnt<=c, ovf<=o.
  - Closing:
    - out_sum<=s[ACC_W-1:0], out_count<=c, out_overflow<=o, out_valid<=1.
    - acc<=0, cnt<=0, ovf<=0; state<=HOLD.
- ACCUM with no accepted beat: registers hold.
- clear in ACCUM: acc, cnt, ovf <=0; no beat is accepted that cycle, because in_ready is low.
- State HOLD:
  - in_ready=0; out_* stable and out_valid=1 until taken.
  - On take: out_valid<=0, state<=ACCUM. out_sum, out_count and out_overflow keep their last values.
  - clear is ignored in HOLD.
- Latency:
  - out_valid rises the cycle after the closing beat is accepted.
  - Minimum one-cycle bubble between groups: no new beat is accepted in the take cycle.
- Arithmetic:
  - Unsigned throughout; sum wraps modulo 2^ACC_W.
  - out_overflow is sticky within a group and cleared per group.
- A single-beat group (in_last on the first beat) gives out_count=1 and out_sum=in_product.
- rst mid-group or in HOLD: all state returns to reset values on the next edge; a pending result is dropped.
- Throughput: one beat per cycle while in ACCUM.

Test Plan:
- Basic group, ACC_W=32:
  - Stimulus: beats 4 then 16 (products of 2*2 and 4*4) with in_last on 16, out_ready=1.
  - Response: out_valid one cycle later; out_sum=20, out_count=2, out_overflow=0; in_ready low that cycle.
- Backpressure:
  - Stimulus: group {1,2,3,last}, out_ready=0 for 5 cycles.
  - Response: out_sum=6 and out_count=3 stable and out_valid=1 for all 5 cycles; in_ready=0; a beat offered meanwhile is not consumed and is accepted only after the take.
- Overflow with ACC_W=20:
  - Stimulus: five beats of 0x3FFFF, last on the fifth.
  - Response: out_sum=262139, out_count=5, out_overflow=1; the next group {7,last} gives out_sum=7, out_overflow=0.
- Forced close with MAX_TERMS=3:
  - Stimulus: beats 10, 20, 30, 40 with in_last never asserted.
  - Response: first result out_sum=60, out_count=3; beat 40 starts the next group.
- Clear:
  - Stimulus: beats 5, 6, then clear with in_valid=1 and in_product=9, then {8,last}.
  - Response: the beat with product 9 is not accepted; result out_sum=8, out_count=1.
- Reset mid-operation:
  - Stimulus: rst for one cycle after beats 100, 200; then {3,last}.
  - Response: out_valid=0 and in_ready=0 during rst; result out_sum=3, out_count=1.
